// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic             op_div, neg_q, neg_r, div0;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;

  // Operand magnitudes and signs at start; op[0]=1 selects the unsigned variants.
  logic             a_sgn, b_sgn;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_sgn = ~op[0] & a[WIDTH-1];
  assign b_sgn = ~op[0] & b[WIDTH-1];
  assign a_mag = a_sgn ? -a : a;
  assign b_mag = b_sgn ? -b : b;

  // Step datapath: acc_lo holds the multiplier / dividend bits being consumed.
  logic [WIDTH:0]     msum, dshift, ddiff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;

  always_comb begin
    msum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    dshift   = {acc_hi, acc_lo[WIDTH-1]};
    ddiff    = dshift - {1'b0, opnd};
    prod     = {acc_hi, acc_lo};
    prod_fix = neg_q ? -prod : prod;
    // Divide by zero leaves the dividend as remainder; force the quotient to all ones.
    q_fix    = div0 ? '1 : (neg_q ? -acc_lo : acc_lo);
    r_fix    = neg_r ? -acc_hi : acc_hi;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (cnt == CW'(WIDTH - 1)) state_n = FIX;
      FIX:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      cnt    <= '0;
      op_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            op_div <= op[1];
            neg_q  <= a_sgn ^ b_sgn;
            neg_r  <= a_sgn;
            div0   <= op[1] && (b == '0);
            acc_hi <= '0;
            acc_lo <= a_mag;
            opnd   <= b_mag;
            cnt    <= '0;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (op_div) begin
            if (!ddiff[WIDTH]) begin
              acc_hi <= ddiff[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi <= dshift[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_hi <= msum[WIDTH:1];
            acc_lo <= {msum[0], acc_lo[WIDTH-1:1]};
          end
        end
        FIX: begin
          done <= 1'b1;
          if (op_div) begin
            hi <= r_fix;
            lo <= q_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: products, quotients, divide-by-zero,
// busy-time start/MT rejection, back-to-back issue and mid-operation reset.
module tb_mul_div_unit;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  logic        clock = 1'b0;
  logic        resetn;
  logic        start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic [31:0] hi, lo;
  logic        busy, done;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cycles;
  int done_seen;

  mul_div_unit #(.WIDTH(32)) dut (
    .clock(clock), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge; the request is sampled at the next edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clock); #1;
    start = 1'b0;
    busy_cycles = 0;
  endtask

  task automatic wait_done();
    while (busy && busy_cycles < 200) begin
      busy_cycles++;
      @(posedge clock); #1;
    end
  endtask

  task automatic run_check(input string tag, input logic [1:0] o, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    issue(o, x, y);
    wait_done();
    check({tag, "_cycles"}, 32'(busy_cycles), 32'd33);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
    @(posedge clock); #1;
    check({tag, "_done_once"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    resetn = 1'b1;
    @(posedge clock); #1;

    run_check("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_check("mult_neg", MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_check("mult_2neg", MULT, 32'hFFFF_FFFC, 32'hFFFF_FFFB, 32'h0, 32'd20);
    run_check("div_neg", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_check("div_negb", DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    run_check("divu", DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_check("divu_zero", DIVU, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF);
    run_check("div_zero_neg", DIV, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_check("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

    // MT writes while idle, both registers in one cycle.
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h55;
    @(posedge clock); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    check("mt_hi", hi, 32'h55);
    check("mt_lo", lo, 32'h55);
    check("mt_no_done", {31'd0, done}, 32'd0);

    // Start and MTHI during busy are dropped.
    issue(MULTU, 32'd5, 32'd6);
    repeat (9) @(posedge clock);
    #1;
    start = 1'b1; op = DIVU; a = 32'd99; b = 32'd3; hi_we = 1'b1; wdata = 32'hDEAD;
    @(posedge clock); #1;
    start = 1'b0; hi_we = 1'b0;
    check("busy_mt_hi_held", hi, 32'h55);
    check("busy_lo_held", lo, 32'h55);
    busy_cycles = 10;
    wait_done();
    check("t5_cycles", 32'(busy_cycles), 32'd33);
    check("t5_done", {31'd0, done}, 32'd1);
    check("t5_hi", hi, 32'h0);
    check("t5_lo", lo, 32'd30);
    // Back-to-back: issue in the done cycle.
    run_check("b2b_divu", DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    check("no_queued_op", {31'd0, busy}, 32'd0);

    // Reset in the middle of a divide.
    issue(DIVU, 32'd1000, 32'd3);
    repeat (19) @(posedge clock);
    #1;
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    resetn = 1'b0;
    #1;
    check("mid_rst_hi", hi, 32'h0);
    check("mid_rst_lo", lo, 32'h0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done || busy) done_seen++;
    end
    check("post_rst_quiet", 32'(done_seen), 32'd0);
    run_check("post_rst_divu", DIVU, 32'd1000, 32'd3, 32'd1, 32'd333);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
